// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master arbiter for the shared system memory bus; serialises
//            accesses, waits the fixed read latency and acks the owner.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int AW         = 20,
    parameter int DW         = 8,
    parameter int LATENCY    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_out,
    output logic [DW-1:0] m0_in,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_out,
    output logic [DW-1:0] m1_in,
    output logic          m1_ack,
    output logic [AW-1:0] address,
    output logic [DW-1:0] out,
    output logic          we,
    input  logic [DW-1:0] in,
    output logic          busy,
    output logic          grant
);

    localparam logic [2:0] c_LAT_M1 = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_count;
    logic       r_is_write;
    logic       w_any;
    logic       w_sel;

    // On a tie, round-robin hands the bus to whoever did not own it last.
    always_comb begin
        w_any = m0_req | m1_req;
        w_sel = 1'b0;
        if (m0_req && m1_req) begin
            w_sel = (FIXED_PRIO != 0) ? 1'b0 : ~grant;
        end else if (m1_req) begin
            w_sel = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 3'd0;
            r_is_write <= 1'b0;
            address    <= '0;
            out        <= '0;
            we         <= 1'b0;
            m0_in      <= '0;
            m1_in      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            busy       <= 1'b0;
            grant      <= 1'b1;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    we <= 1'b0;
                    if (w_any) begin
                        grant      <= w_sel;
                        address    <= w_sel ? m1_address : m0_address;
                        out        <= w_sel ? m1_out : m0_out;
                        we         <= w_sel ? m1_we : m0_we;
                        r_is_write <= w_sel ? m1_we : m0_we;
                        busy       <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // Write strobe is exactly the single ISSUE cycle.
                    we      <= 1'b0;
                    r_count <= c_LAT_M1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_count == 3'd0) begin
                        if (!r_is_write) begin
                            if (grant) m1_in <= in;
                            else       m0_in <= in;
                        end
                        if (grant) m1_ack <= 1'b1;
                        else       m0_ack <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count - 3'd1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter that shares the single 8-bit system memory bus (20-bit address, data out, data in, we) between the CPU core (master 0) and a second requester such as disk/SD DMA (master 1).
- Sits between the masters and the address-decode memory router.
- Serialises accesses, drives the bus from registers, waits the fixed memory read latency, then returns read data with a one-cycle acknowledge.

Parameters:
AW, 20, address width
DW, 8, data width
LATENCY, 1, memory read latency in clock cycles, from bus address valid to bus data valid; legal range 1..7
FIXED_PRIO, 0, 0 = round-robin on ties; 1 = master 0 always wins ties

Ports:
clock  input  1  system clock; all registers use its rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 request; held with address/we/data until m0_ack
m0_we  input  1  master 0 write (1) / read (0)
m0_address  input  AW  master 0 address
m0_out  input  DW  master 0 write data
m0_in  output  DW  master 0 read data, registered
m0_ack  output  1  master 0 completion pulse
m1_req, m1_we, m1_address, m1_out, m1_in, m1_ack  (same widths and directions as master 0)  master 1 equivalents
address  output  AW  bus address, registered
out  output  DW  bus write data, registered
we  output  1  bus write strobe, registered
in  input  DW  bus read data from the router
busy  output  1  high in every state except IDLE
grant  output  1  owner of the current or last transaction (0/1)

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, we=0, address=0, out=0.
  - m0_in=m1_in=0, m0_ack=m1_ack=0, busy=0.
  - grant=1, so master 0 wins the first tie under round-robin.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples m0_req/m1_req each cycle.
  - One request: grant that master.
  - Both requests, FIXED_PRIO=0: grant the master that is not the current grant. FIXED_PRIO=1: grant master 0.
  - On grant, load address, out and we from the selected master, update grant, go to ISSUE.
  - No request: remain in IDLE; we=0; address/out hold their last values.
- ISSUE (1 cycle):
  - Bus shows address/out/we.
  - Leaving ISSUE clears we, so a write strobe lasts exactly one cycle.
  - Load the wait counter with LATENCY-1; go to WAIT.
- WAIT (LATENCY cycles):
  - address holds and we=0.
  - When the counter reaches 0, capture in into the granted master's m*_in (for reads only; writes leave m*_in unchanged). Go to DONE.
- DONE (1 cycle):
  - The granted master's m*_ack=1; the other ack stays 0.
  - Next state is IDLE.
- Latency, request seen high in IDLE at cycle 0:
  - Bus valid at cycle 1.
  - Ack at cycle 2+LATENCY (cycle 3 for LATENCY=1).
  - Minimum spacing between transactions is 3+LATENCY cycles.
- Handshake:
  - The master keeps req and its signals stable until it sees ack.
  - The master drops req in the cycle after ack. A req still high in the IDLE cycle after DONE counts as a new request and starts a new transaction.
  - Requests are ignored in ISSUE, WAIT and DONE. Changes to a master's signals in those states have no effect.
- m*_in holds its value until that master's next read completes.
- Acks are never asserted simultaneously, and never outside DONE.
- Reset mid-transaction:
  - Return to IDLE immediately and force we=0 asynchronously.
  - No ack is issued for the aborted transaction.
  - A held req is re-arbitrated after reset releases.
- A request changing between IDLE samples is legal; only the value at the granting edge matters.

Test Plan:
- Read, LATENCY=1: memory model returns 8'hA5 at 20'hFE000; m0 read -> address=20'hFE000 at cycle 1, we=0 throughout, m0_ack pulse at cycle 3, m0_in=8'hA5, m1_ack=0.
- Write: m1 write to 20'hB8000, data 8'h3C -> we=1 for exactly one cycle (cycle 1) with out=8'h3C; m1_ack at cycle 3; m1_in unchanged.
- Tie, round-robin, both reqs held continuously, FIXED_PRIO=0: grant sequence m0, m1, m0, m1; acks 4 cycles apart; busy drops to 0 for exactly one IDLE cycle between transactions.
- Tie, FIXED_PRIO=1, both reqs held: every grant is m0 and m1 is never acked; after m0_req drops, m1 is granted on the next IDLE cycle.
- Latency: LATENCY=4, m1 read -> ack at cycle 6; in is sampled at the end of cycle 5. Toggling in earlier has no effect on m1_in.
- Reset: reset asserted during ISSUE of an m0 write -> we=0 immediately, no ack. After release with m0_req still high, the write reissues and completes normally.
